// File: rtl/dp_pipe_pkg.sv
// Shared definitions for the DP_pipe dot-product datapath and its sequencing controller.
// Holds the precision-mode codes, the controller FSM states and the default
// pipeline geometry so that datapath and controller agree on depth and widths.
package dp_pipe_pkg;

  // Number of pipeline register stages between operand capture and result.
  localparam int unsigned DefaultStages = 5;
  // Width of the precision-mode code.
  localparam int unsigned DefaultModeW  = 2;
  // Width of the completed-operation counter.
  localparam int unsigned DefaultCntW   = 16;

  // Precision modes understood by the multi-precision datapath.
  typedef enum logic [1:0] {
    MODE_FP64   = 2'd0,
    MODE_FP32X2 = 2'd1,
    MODE_FP16X4 = 2'd2,
    MODE_BF16X4 = 2'd3
  } mode_e;

  // Controller sequencing states.
  //   StIdle  : pipeline empty, any mode may be accepted
  //   StRun   : pipeline occupied with operands of cur_mode
  //   StDrain : a different mode is waiting; intake blocked until empty
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/dp_pipe_ctrl_if.sv
// Handshake bundle between the DP_pipe controller and its environment.
//   in_valid/in_ready/in_mode/in_last : upstream operand-set handshake
//   out_valid/out_ready/out_last      : downstream result handshake
//   stage_en/stage_vld                : per-stage load enables and occupancy
//   cur_mode                          : mode currently configured in the datapath
//   flush                             : synchronous pipeline clear
//   busy/op_count                     : status and saturating result count
// Modports: master = environment (drives requests), slave = controller.
interface dp_pipe_ctrl_if
  import dp_pipe_pkg::*;
#(
  parameter int unsigned STAGES = DefaultStages,
  parameter int unsigned MODE_W = DefaultModeW,
  parameter int unsigned CNT_W  = DefaultCntW
);

  logic              in_valid;
  logic              in_ready;
  logic [MODE_W-1:0] in_mode;
  logic              in_last;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_vld;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [MODE_W-1:0] cur_mode;
  logic              flush;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  modport master (
    output in_valid, in_mode, in_last, out_ready, flush,
    input  in_ready, stage_en, stage_vld, out_valid, out_last, cur_mode, busy, op_count
  );

  modport slave (
    input  in_valid, in_mode, in_last, out_ready, flush,
    output in_ready, stage_en, stage_vld, out_valid, out_last, cur_mode, busy, op_count
  );

endinterface

// File: rtl/dp_pipe_vld_stage.sv
// One slot of the elastic valid chain: holds the valid bit and the
// end-of-accumulation tag of a single pipeline register stage.
//   clk, rst      : clock, asynchronous active-low reset
//   flush_i       : synchronous clear of the slot
//   up_vld_i      : the stage feeding this slot holds data (or in_fire at stage 0)
//   up_last_i     : end-of-group tag travelling with that data
//   dn_rdy_i      : the next stage (or downstream consumer) can take data
//   rdy_o         : this slot can take data this cycle
//   en_o          : load enable of the matching datapath register
//   vld_o/last_o  : slot occupancy and tag
module dp_pipe_vld_stage
  import dp_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic up_vld_i,
  input  logic up_last_i,
  input  logic dn_rdy_i,
  output logic rdy_o,
  output logic en_o,
  output logic vld_o,
  output logic last_o
);

  logic vld_q, vld_d;
  logic last_q, last_d;

  // An empty slot is always ready, so bubbles collapse under a stall.
  assign rdy_o = ~vld_q | dn_rdy_i;

  // Only real data toggles the datapath register; nothing loads in a flush cycle.
  assign en_o = rdy_o & up_vld_i & ~flush_i;

  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    if (flush_i) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end else if (rdy_o) begin
      vld_d  = up_vld_i;
      // Tag is cleared with a bubble so an empty slot never reports last.
      last_d = up_vld_i & up_last_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign vld_o  = vld_q;
  assign last_o = last_q;

endmodule

// File: rtl/dp_pipe_ctrl.sv
// Sequencing controller for the multi-precision dot-product FP pipeline.
// Tracks occupancy of STAGES register stages with an elastic ready chain,
// produces per-stage load enables, keeps a single precision mode in flight
// (a mode change drains the pipeline first), supports a synchronous flush and
// counts delivered results with a saturating counter.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : controller side of the handshake bundle (see dp_pipe_ctrl_if)
module dp_pipe_ctrl
  import dp_pipe_pkg::*;
#(
  parameter int unsigned STAGES = DefaultStages,  // >= 2
  parameter int unsigned MODE_W = DefaultModeW,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input logic           clk,
  input logic           rst,
  dp_pipe_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] cur_mode_q, cur_mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [STAGES-1:0] rdy_vec;
  logic [STAGES-1:0] up_vec;
  logic [STAGES-1:0] en_vec;
  logic [STAGES-1:0] vld_vec;

  logic occupied;
  logic occ_next;
  logic mode_ok;
  logic in_ready;
  logic in_fire;
  logic out_fire;

  // Stage slots. Each slot keeps its own scalar nets so the ready chain is a
  // plain cascade from the output end back to stage 0.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic rdy;
    logic dn_rdy;
    logic up_vld;
    logic up_last;
    logic en;
    logic vld;
    logic last;

    if (i == STAGES - 1) begin : g_tail
      assign dn_rdy = bus.out_ready;
    end else begin : g_body
      assign dn_rdy = g_stage[i+1].rdy;
    end

    if (i == 0) begin : g_head
      assign up_vld  = in_fire;
      assign up_last = bus.in_last;
    end else begin : g_link
      assign up_vld  = g_stage[i-1].vld;
      assign up_last = g_stage[i-1].last;
    end

    dp_pipe_vld_stage u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (bus.flush),
      .up_vld_i  (up_vld),
      .up_last_i (up_last),
      .dn_rdy_i  (dn_rdy),
      .rdy_o     (rdy),
      .en_o      (en),
      .vld_o     (vld),
      .last_o    (last)
    );

    assign rdy_vec[i] = rdy;
    assign up_vec[i]  = up_vld;
    assign en_vec[i]  = en;
    assign vld_vec[i] = vld;
  end

  assign occupied = |vld_vec;

  // Occupancy after this edge, ignoring flush (flush forces IDLE anyway).
  // Lets RUN fall to IDLE on the same edge that empties the last stage.
  assign occ_next = |((rdy_vec & up_vec) | (~rdy_vec & vld_vec));

  // Mode match uses current occupancy; a result leaving this cycle does not
  // yet make room for a different mode.
  assign mode_ok  = (bus.in_mode == cur_mode_q) | ~occupied;
  assign in_ready = g_stage[0].rdy & ~bus.flush & (state_q != StDrain) & mode_ok;
  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = g_stage[STAGES-1].vld & bus.out_ready;

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    cnt_d      = cnt_q;

    // Mode is taken on every accepted set; only IDLE can actually change it.
    if (in_fire) begin
      cur_mode_d = bus.in_mode;
    end

    // Flush-cycle deliveries still count.
    if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      StIdle: begin
        if (in_fire) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.in_valid && (bus.in_mode != cur_mode_q)) begin
          state_d = StDrain;
        end else if (!occ_next) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Stays in DRAIN even if upstream withdraws in_valid.
        if (!occupied) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (bus.flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_mode_q <= MODE_W'(MODE_FP64);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.stage_en  = en_vec;
  assign bus.stage_vld = vld_vec;
  assign bus.out_valid = g_stage[STAGES-1].vld;
  assign bus.out_last  = g_stage[STAGES-1].last;
  assign bus.cur_mode  = cur_mode_q;
  assign bus.busy      = occupied | (state_q != StIdle);
  assign bus.op_count  = cnt_q;

endmodule

// File: doc/dp_pipe_ctrl.md
Name: dp_pipe_ctrl

Overview:
- Sequencing controller for the multi-precision dot-product FP pipeline (DP_pipe).
- Tracks a valid bit per pipeline register stage and generates per-stage load enables with elastic backpressure.
- Enforces a single precision mode in flight: a mode change drains the pipeline first.
- Provides synchronous flush, end-of-accumulation tagging and a completed-operation counter.

Parameters:
- STAGES, 5, number of pipeline register stages sequenced (stage 0 = input side); minimum 2.
- MODE_W, 2, width of the precision-mode code.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream operand set valid
- in_ready  output  1  controller accepts the operand set this cycle
- in_mode  input  MODE_W  precision mode of the incoming operand set
- in_last  input  1  operand set closes an accumulation group
- stage_en  output  STAGES  load enable of each stage register
- stage_vld  output  STAGES  occupancy of each stage
- out_valid  output  1  last stage holds a result
- out_ready  input  1  downstream accepts the result
- out_last  output  1  result closes an accumulation group
- cur_mode  output  MODE_W  mode currently configured in the datapath
- flush  input  1  synchronous pipeline clear
- busy  output  1  any stage occupied or state != IDLE
- op_count  output  CNT_W  saturating count of results delivered

Behaviour:
- Reset (rst low, async): stage_vld=0, last tags=0, cur_mode=0, op_count=0, state=IDLE. Consequently out_valid=0, out_last=0, busy=0, stage_en=0. in_ready is combinational and is not 0 in reset: it equals 1 whenever in_valid=0, or when in_valid=1 with an accepted mode, per the in_ready rule below.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Elastic ready chain (combinational):
  - rdy[STAGES-1] = ~vld[STAGES-1] | out_ready
  - rdy[i] = ~vld[i] | rdy[i+1]
- Upstream valid: up[0] = in_fire; up[i] = vld[i-1].
- Enables: stage_en[i] = rdy[i] & up[i]. Only valid data is loaded; bubbles do not toggle datapath registers.
- Occupancy update: if rdy[i], vld[i] <= up[i] and last[i] <= up-last; else hold. Bubbles collapse, so a stall only fills empty slots.
- Latency: an accepted operand set appears at out_valid exactly STAGES cycles after in_fire when there is no backpressure. Throughput is 1 per cycle.
- out_valid = vld[STAGES-1]; out_last = last[STAGES-1].
- FSM states:
  - IDLE: pipeline empty.
  - RUN: at least one stage occupied, mode matches.
  - DRAIN: a pending in_mode differs from cur_mode while occupied.
- in_ready = rdy[0] & ~flush & (state != DRAIN) & (in_mode == cur_mode | pipeline empty, ignoring this cycle's out_fire).
- Transitions:
  - IDLE -> RUN on in_fire. If in_mode != cur_mode, cur_mode <= in_mode in the same cycle; no dead cycle.
  - RUN -> DRAIN when in_valid & in_mode != cur_mode.
  - RUN -> IDLE when the last occupied stage empties and there is no in_fire.
  - DRAIN -> IDLE when all vld are 0 (in_ready=0 throughout DRAIN). The new mode is then accepted in the following cycle via the IDLE rule.
  - Upstream withdrawing in_valid during DRAIN does not abort the drain.
- Flush (any state):
  - Next cycle: all vld=0, last=0, state=IDLE; cur_mode and op_count are kept.
  - in_ready=0 and stage_en=0 during the flush cycle. out_fire in a flush cycle is still counted.
- op_count increments on out_fire and saturates at all-ones (no wrap).
- Simultaneous in_fire and out_fire with a full pipeline: allowed; every stage advances.
- Reset mid-operation: immediate return to reset values; in-flight data is discarded.

Decomposition:
- Shared package dp_pipe_pkg holds:
  - the mode enum (MODE_FP64, MODE_FP32X2, MODE_FP16X4, MODE_BF16X4)
  - the FSM state enum
  - the default STAGES constant, so datapath and controller agree on depth
- One natural sub-module, dp_pipe_vld_stage: a single-stage valid/last slot computing rdy/en and holding vld/last, instantiated STAGES times by a generate loop. The FSM and counter stay in the top.

Test Plan:
- Streaming: reset, STAGES=5, out_ready=1, 8 back-to-back in_valid, mode 0 -> first out_valid 5 cycles after first in_fire, 8 consecutive out_valid, op_count=8, busy falls 1 cycle after last out_fire.
- Backpressure: fill 5 ops, hold out_ready=0 for 10 cycles -> stage_vld=5'b11111, in_ready=0, stage_en=0, no data loss; release -> 5 results in order with last tags preserved.
- Bubble collapse: ops at cycles 0, 2, 4, out_ready=0 from cycle 3 -> the ops stack into the last 3 stages; in_ready stays 1 until stage 0 is occupied.
- Mode change: 3 ops in mode 0, then in_valid with mode 2 -> DRAIN, in_ready=0 until stage_vld=0, then accepted; cur_mode=2 only after the mode-0 results leave.
- Flush: pipeline holding 4 ops, flush pulse 1 cycle -> next cycle stage_vld=0, out_valid=0, state IDLE, op_count unchanged, cur_mode unchanged.
- Saturation/reset: CNT_W=3, 9 results -> op_count=7; drop rst mid-stream -> all outputs at reset values asynchronously before the next clk edge.
